// File: rtl/pu_or1k_wb_pkg.sv
// Shared types for the cappuccino writeback-result stage.
// Holds the load-tracking state encoding and LSU access sizes.
package pu_or1k_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_LSU = 2'd1,
        ST_DRAIN    = 2'd2
    } wb_state_e;

    localparam logic [1:0] LSU_LEN_BYTE = 2'd0;
    localparam logic [1:0] LSU_LEN_HALF = 2'd1;
    localparam logic [1:0] LSU_LEN_WORD = 2'd2;

endpackage

// File: rtl/pu_or1k_load_align.sv
// Big-endian load data alignment and sign/zero extension.
// Purely combinational; word (and unused size 3) passes through.
module pu_or1k_load_align #(
    parameter int OPTION_OPERAND_WIDTH = 32
) (
    input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_dat_i,
    input  logic [1:0]                      len_i,
    input  logic                            zext_i,
    input  logic [1:0]                      adr_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] dat_o
);
    import pu_or1k_wb_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane, then extend to the full datapath width.
    always_comb begin
        byte_sel = 8'h00;
        unique case (adr_i)
            2'd0: byte_sel = lsu_dat_i[31:24];
            2'd1: byte_sel = lsu_dat_i[23:16];
            2'd2: byte_sel = lsu_dat_i[15:8];
            2'd3: byte_sel = lsu_dat_i[7:0];
        endcase
        half_sel = adr_i[1] ? lsu_dat_i[15:0] : lsu_dat_i[31:16];
        if (len_i == LSU_LEN_BYTE) begin
            dat_o = {{24{~zext_i & byte_sel[7]}}, byte_sel};
        end else if (len_i == LSU_LEN_HALF) begin
            dat_o = {{16{~zext_i & half_sel[15]}}, half_sel};
        end else begin
            dat_o = lsu_dat_i;
        end
    end

endmodule

// File: rtl/pu_or1k_wb_result_cappuccino.sv
// Writeback-result stage: selects ALU/mul/SPR/load result for the RF.
// Stalls ctrl while a load is outstanding and drains flushed loads.
module pu_or1k_wb_result_cappuccino #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            padv_ctrl_i,
    input  logic                            ctrl_valid_i,
    input  logic                            ctrl_rf_wb_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] ctrl_rfd_adr_i,
    input  logic                            ctrl_op_lsu_load_i,
    input  logic                            ctrl_op_mul_i,
    input  logic                            ctrl_op_mfspr_i,
    input  logic [1:0]                      ctrl_lsu_length_i,
    input  logic                            ctrl_lsu_zext_i,
    input  logic [1:0]                      ctrl_lsu_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_alu_result_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] mul_result_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] spr_dat_i,
    input  logic                            lsu_valid_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_dat_i,
    input  logic                            pipeline_flush_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] result_o,
    output logic                            wb_rf_wb_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_o,
    output logic                            wb_stall_o
);
    import pu_or1k_wb_pkg::*;

    wb_state_e                       state_q, state_d;
    logic [1:0]                      len_q, len_d;
    logic                            zext_q, zext_d;
    logic [1:0]                      adr_q, adr_d;
    logic                            ld_wb_q, ld_wb_d;
    logic [OPTION_OPERAND_WIDTH-1:0] result_q, result_d;
    logic                            rf_wb_q, rf_wb_d;
    logic [OPTION_RF_ADDR_WIDTH-1:0] rfd_adr_q, rfd_adr_d;

    logic                            idle;
    logic                            accept;
    logic [1:0]                      al_len;
    logic                            al_zext;
    logic [1:0]                      al_adr;
    logic [OPTION_OPERAND_WIDTH-1:0] al_dat;

    // New work is only taken while no load is outstanding.
    assign idle    = (state_q == ST_IDLE);
    assign accept  = padv_ctrl_i & ctrl_valid_i & idle;

    // Same-cycle loads align from ctrl; waiting loads use latched fields.
    assign al_len  = idle ? ctrl_lsu_length_i : len_q;
    assign al_zext = idle ? ctrl_lsu_zext_i   : zext_q;
    assign al_adr  = idle ? ctrl_lsu_adr_i    : adr_q;

    pu_or1k_load_align #(
        .OPTION_OPERAND_WIDTH(OPTION_OPERAND_WIDTH)
    ) u_align (
        .lsu_dat_i (lsu_dat_i),
        .len_i     (al_len),
        .zext_i    (al_zext),
        .adr_i     (al_adr),
        .dat_o     (al_dat)
    );

    // Result selection, load tracking and flush handling.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        zext_d    = zext_q;
        adr_d     = adr_q;
        ld_wb_d   = ld_wb_q;
        result_d  = result_q;
        rfd_adr_d = rfd_adr_q;
        rf_wb_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rfd_adr_d = ctrl_rfd_adr_i;
                    if (ctrl_op_lsu_load_i) begin
                        if (lsu_valid_i) begin
                            result_d = al_dat;
                            rf_wb_d  = ctrl_rf_wb_i & ~pipeline_flush_i;
                        end else if (!pipeline_flush_i) begin
                            state_d = ST_WAIT_LSU;
                            len_d   = ctrl_lsu_length_i;
                            zext_d  = ctrl_lsu_zext_i;
                            adr_d   = ctrl_lsu_adr_i;
                            ld_wb_d = ctrl_rf_wb_i;
                        end
                    end else begin
                        if (ctrl_op_mfspr_i) begin
                            result_d = spr_dat_i;
                        end else if (ctrl_op_mul_i) begin
                            result_d = mul_result_i;
                        end else begin
                            result_d = ctrl_alu_result_i;
                        end
                        rf_wb_d = ctrl_rf_wb_i & ~pipeline_flush_i;
                    end
                end
            end
            ST_WAIT_LSU: begin
                if (pipeline_flush_i) begin
                    state_d = lsu_valid_i ? ST_IDLE : ST_DRAIN;
                end else if (lsu_valid_i) begin
                    result_d = al_dat;
                    rf_wb_d  = ld_wb_q;
                    state_d  = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (lsu_valid_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered writeback outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            len_q     <= LSU_LEN_WORD;
            zext_q    <= 1'b0;
            adr_q     <= 2'd0;
            ld_wb_q   <= 1'b0;
            result_q  <= '0;
            rf_wb_q   <= 1'b0;
            rfd_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            zext_q    <= zext_d;
            adr_q     <= adr_d;
            ld_wb_q   <= ld_wb_d;
            result_q  <= result_d;
            rf_wb_q   <= rf_wb_d;
            rfd_adr_q <= rfd_adr_d;
        end
    end

    // Stall is released combinationally when load data arrives.
    assign wb_stall_o   = ~idle & ~lsu_valid_i;
    assign result_o     = result_q;
    assign wb_rf_wb_o   = rf_wb_q;
    assign wb_rfd_adr_o = rfd_adr_q;

endmodule

// File: tb/tb_pu_or1k_wb_result_cappuccino.sv
// Self-checking bench for the cappuccino writeback-result stage.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_pu_or1k_wb_result_cappuccino;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        padv_ctrl_i, ctrl_valid_i, ctrl_rf_wb_i;
    logic [4:0]  ctrl_rfd_adr_i;
    logic        ctrl_op_lsu_load_i, ctrl_op_mul_i, ctrl_op_mfspr_i;
    logic [1:0]  ctrl_lsu_length_i;
    logic        ctrl_lsu_zext_i;
    logic [1:0]  ctrl_lsu_adr_i;
    logic [31:0] ctrl_alu_result_i, mul_result_i, spr_dat_i;
    logic        lsu_valid_i;
    logic [31:0] lsu_dat_i;
    logic        pipeline_flush_i;
    logic [31:0] result_o;
    logic        wb_rf_wb_o;
    logic [4:0]  wb_rfd_adr_o;
    logic        wb_stall_o;

    int n_total = 0;
    int n_pass  = 0;

    // Model: 0 = nothing outstanding, 1 = waiting for load, 2 = draining.
    int          m_mode = 0;
    int          m_len, m_adr;
    bit          m_zext, m_wb;
    logic [31:0] exp_result = 0;
    bit          exp_wb = 0;
    logic [4:0]  exp_adr = 0;

    pu_or1k_wb_result_cappuccino dut (
        .clk                (clk),
        .rst                (rst),
        .padv_ctrl_i        (padv_ctrl_i),
        .ctrl_valid_i       (ctrl_valid_i),
        .ctrl_rf_wb_i       (ctrl_rf_wb_i),
        .ctrl_rfd_adr_i     (ctrl_rfd_adr_i),
        .ctrl_op_lsu_load_i (ctrl_op_lsu_load_i),
        .ctrl_op_mul_i      (ctrl_op_mul_i),
        .ctrl_op_mfspr_i    (ctrl_op_mfspr_i),
        .ctrl_lsu_length_i  (ctrl_lsu_length_i),
        .ctrl_lsu_zext_i    (ctrl_lsu_zext_i),
        .ctrl_lsu_adr_i     (ctrl_lsu_adr_i),
        .ctrl_alu_result_i  (ctrl_alu_result_i),
        .mul_result_i       (mul_result_i),
        .spr_dat_i          (spr_dat_i),
        .lsu_valid_i        (lsu_valid_i),
        .lsu_dat_i          (lsu_dat_i),
        .pipeline_flush_i   (pipeline_flush_i),
        .result_o           (result_o),
        .wb_rf_wb_o         (wb_rf_wb_o),
        .wb_rfd_adr_o       (wb_rfd_adr_o),
        .wb_stall_o         (wb_stall_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_load(logic [31:0] d, int len,
                                             bit zx, int adr);
        logic [31:0] v;
        if (len == 0) begin
            v = (d >> (8 * (3 - adr))) & 32'hFF;
            if (!zx && v[7]) v = v | 32'hFFFFFF00;
        end else if (len == 1) begin
            v = (d >> (16 * (1 - adr / 2))) & 32'hFFFF;
            if (!zx && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_mode = 0; exp_result = 0; exp_wb = 0; exp_adr = 0; m_wb = 0;
    endtask

    // Apply the writeback rules to the inputs presented this cycle.
    task automatic model_step();
        bit acc;
        acc = padv_ctrl_i && ctrl_valid_i && (m_mode == 0);
        exp_wb = 0;
        if (m_mode == 0) begin
            if (acc) begin
                exp_adr = ctrl_rfd_adr_i;
                if (ctrl_op_lsu_load_i) begin
                    if (lsu_valid_i) begin
                        exp_result = ref_load(lsu_dat_i, ctrl_lsu_length_i,
                                              ctrl_lsu_zext_i, ctrl_lsu_adr_i);
                        exp_wb = ctrl_rf_wb_i && !pipeline_flush_i;
                    end else if (!pipeline_flush_i) begin
                        m_mode = 1;
                        m_len  = ctrl_lsu_length_i;
                        m_zext = ctrl_lsu_zext_i;
                        m_adr  = ctrl_lsu_adr_i;
                        m_wb   = ctrl_rf_wb_i;
                    end
                end else begin
                    exp_result = ctrl_op_mfspr_i ? spr_dat_i :
                                 ctrl_op_mul_i ? mul_result_i :
                                 ctrl_alu_result_i;
                    exp_wb = ctrl_rf_wb_i && !pipeline_flush_i;
                end
            end
        end else if (m_mode == 1) begin
            if (pipeline_flush_i) m_mode = lsu_valid_i ? 0 : 2;
            else if (lsu_valid_i) begin
                exp_result = ref_load(lsu_dat_i, m_len, m_zext, m_adr);
                exp_wb = m_wb;
                m_mode = 0;
            end
        end else begin
            if (lsu_valid_i) m_mode = 0;
        end
    endtask

    // One cycle: inputs are already driven; check stall, step, check regs.
    task automatic tick();
        #1;
        chk("stall", wb_stall_o, (m_mode != 0) && !lsu_valid_i);
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("result", result_o, exp_result);
        chk("rf_wb", wb_rf_wb_o, exp_wb);
        chk("rfd_adr", wb_rfd_adr_o, exp_adr);
    endtask

    task automatic clr();
        padv_ctrl_i = 0; ctrl_valid_i = 0; ctrl_rf_wb_i = 0;
        ctrl_rfd_adr_i = 0; ctrl_op_lsu_load_i = 0; ctrl_op_mul_i = 0;
        ctrl_op_mfspr_i = 0; ctrl_lsu_length_i = 2; ctrl_lsu_zext_i = 0;
        ctrl_lsu_adr_i = 0; ctrl_alu_result_i = 0; mul_result_i = 0;
        spr_dat_i = 0; lsu_valid_i = 0; lsu_dat_i = 0;
        pipeline_flush_i = 0;
    endtask

    task automatic issue(input bit ld, input logic [4:0] rfd);
        padv_ctrl_i = 1; ctrl_valid_i = 1; ctrl_rf_wb_i = 1;
        ctrl_op_lsu_load_i = ld; ctrl_rfd_adr_i = rfd;
    endtask

    initial begin
        int stall_cnt;
        clr();
        @(negedge clk);
        @(negedge clk);
        chk("reset result", result_o, 32'h0);
        chk("reset rf_wb", wb_rf_wb_o, 1'b0);
        chk("reset rfd", wb_rfd_adr_o, 5'd0);
        chk("reset stall", wb_stall_o, 1'b0);
        rst = 0;

        // ALU op writes back next cycle, strobe lasts one cycle.
        issue(0, 5'd3); ctrl_alu_result_i = 32'h12345678;
        tick();
        chk("alu result", result_o, 32'h12345678);
        chk("alu rfd", wb_rfd_adr_o, 5'd3);
        chk("alu strobe", wb_rf_wb_o, 1'b1);
        clr();
        tick();
        chk("alu strobe end", wb_rf_wb_o, 1'b0);

        // Signed byte load, data three idle cycles after accept.
        issue(1, 5'd4); ctrl_lsu_length_i = 0; ctrl_lsu_adr_i = 1;
        tick();
        clr();
        stall_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            #1; if (wb_stall_o) stall_cnt++;
            tick();
        end
        chk("byte stall cycles", stall_cnt, 3);
        lsu_valid_i = 1; lsu_dat_i = 32'h11A23344;
        tick();
        chk("byte load", result_o, 32'hFFFFFFA2);
        clr();

        // Zero-extended half load with data on accept.
        issue(1, 5'd5); ctrl_lsu_length_i = 1; ctrl_lsu_zext_i = 1;
        ctrl_lsu_adr_i = 2; lsu_valid_i = 1; lsu_dat_i = 32'hDEAD8001;
        #1; chk("half no stall", wb_stall_o, 1'b0);
        tick();
        chk("half load", result_o, 32'h00008001);
        clr();

        // Flush while waiting: drain and discard.
        issue(1, 5'd9);
        tick();
        clr(); pipeline_flush_i = 1;
        tick();
        clr();
        #1; chk("drain stall", wb_stall_o, 1'b1);
        tick();
        lsu_valid_i = 1; lsu_dat_i = 32'h55555555;
        tick();
        chk("drain no wb", wb_rf_wb_o, 1'b0);
        chk("drain keeps result", result_o, 32'h00008001);
        clr();

        // mfspr beats mul beats ALU.
        issue(0, 5'd6); ctrl_op_mfspr_i = 1; ctrl_op_mul_i = 1;
        spr_dat_i = 32'hCAFE0000; mul_result_i = 32'h0BADF00D;
        ctrl_alu_result_i = 32'h01020304;
        tick();
        chk("priority", result_o, 32'hCAFE0000);
        clr();

        // Asynchronous reset while waiting on a load.
        issue(1, 5'd7);
        tick();
        clr();
        rst = 1;
        #1;
        chk("async result", result_o, 32'h0);
        chk("async rfd", wb_rfd_adr_o, 5'd0);
        chk("async stall", wb_stall_o, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 0;
        lsu_valid_i = 1; lsu_dat_i = 32'hFFFFFFFF;
        tick();
        chk("post reset no wb", wb_rf_wb_o, 1'b0);
        clr();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            clr();
            ctrl_valid_i       = ($urandom_range(9) != 0);
            ctrl_rf_wb_i       = ($urandom_range(7) != 0);
            ctrl_rfd_adr_i     = 5'($urandom);
            ctrl_op_lsu_load_i = ($urandom_range(9) < 4);
            ctrl_op_mul_i      = $urandom_range(1);
            ctrl_op_mfspr_i    = ($urandom_range(3) == 0);
            ctrl_lsu_length_i  = 2'($urandom_range(2));
            ctrl_lsu_zext_i    = $urandom_range(1);
            ctrl_lsu_adr_i     = 2'($urandom);
            ctrl_alu_result_i  = $urandom;
            mul_result_i       = $urandom;
            spr_dat_i          = $urandom;
            lsu_dat_i          = $urandom;
            pipeline_flush_i   = ($urandom_range(19) == 0);
            if (m_mode == 0) begin
                padv_ctrl_i = ($urandom_range(3) != 0);
                lsu_valid_i = ($urandom_range(9) < 3);
            end else begin
                lsu_valid_i = ($urandom_range(9) < 3);
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
